// File: rtl/fc_mult_accumulator.sv
// fc_mult_accumulator: pipelined adder tree + dot-product accumulator for one
// output neuron stream; adds bias, saturates, optional ReLU, valid/ready out.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start, vec_len,      begin a dot product of vec_len beats; relu_en and
//   relu_en, bias        bias latched with the accepted start (IDLE only)
//   in_valid, in_ready,  product beat handshake; mult_din holds 2*PE_Num
//   mult_din             signed dwidth-wide lanes
//   busy                 high whenever not IDLE
//   out_valid, out_ready result handshake
//   dout                 saturated (optionally ReLU'd) result
module fc_mult_accumulator #(
    parameter int dwidth    = 16,
    parameter int qwidth    = 11,
    parameter int PE_Num    = 8,
    parameter int LEN_W     = 10,
    parameter int ACC_GUARD = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [LEN_W-1:0]           vec_len,
    input  logic                       relu_en,
    input  logic [dwidth-1:0]          bias,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2*PE_Num*dwidth-1:0] mult_din,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [dwidth-1:0]          dout
);

    localparam int N     = 2 * PE_Num;
    localparam int L     = $clog2(N);
    localparam int TW    = dwidth + L;
    localparam int ACC_W = dwidth + L + ACC_GUARD;
    localparam int DCW   = $clog2(L + 2);

    localparam logic signed [ACC_W-1:0] MAXV =
        {{(ACC_W-dwidth+1){1'b0}}, {(dwidth-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
    localparam logic [dwidth-1:0] SAT_HI = {1'b0, {(dwidth-1){1'b1}}};
    localparam logic [dwidth-1:0] SAT_LO = {1'b1, {(dwidth-1){1'b0}}};

    // Products arrive pre-aligned to qwidth fractional bits, so qwidth only
    // constrains legal parameter sets here.
    if ((N & (N - 1)) != 0 || qwidth >= dwidth) begin : g_bad_params
        $error("fc_mult_accumulator: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        cnt_q;
    logic                    relu_q;
    logic [dwidth-1:0]       bias_q;
    logic [DCW-1:0]          dcnt_q;
    logic [dwidth-1:0]       dout_q;
    logic signed [ACC_W-1:0] acc_q;

    // Heap-ordered tree: leaves at [N..2N-1], node i = node 2i + node 2i+1,
    // root at [1]. Every node is registered, so the root lags leaves by L.
    logic signed [TW-1:0]    node_q [1:2*N-1];
    logic [L:0]              tag_q;

    logic                    accept;
    logic                    last;
    logic                    start_ok;
    logic                    fire;
    logic signed [ACC_W-1:0] sum;
    logic [dwidth-1:0]       sat;
    logic [dwidth-1:0]       res;

    assign in_ready  = (state_q == S_ACCUM);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign dout      = dout_q;

    assign accept   = in_valid & in_ready;
    assign last     = accept && (cnt_q == len_q - LEN_W'(1));
    assign start_ok = (state_q == S_IDLE) && start;
    assign fire     = (state_q == S_DRAIN) && (dcnt_q == '0);

    always_comb begin
        sum = acc_q + {{(ACC_W-dwidth){bias_q[dwidth-1]}}, bias_q};
        sat = sum[dwidth-1:0];
        if (sum > MAXV) begin
            sat = SAT_HI;
        end else if (sum < MINV) begin
            sat = SAT_LO;
        end
        res = sat;
        if (relu_q && sat[dwidth-1]) begin
            res = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (vec_len == '0) ? S_DRAIN : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == '0) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q  <= '0;
            cnt_q  <= '0;
            relu_q <= 1'b0;
            bias_q <= '0;
            dcnt_q <= '0;
            dout_q <= '0;
            acc_q  <= '0;
            tag_q  <= '0;
            for (int i = 1; i < 2 * N; i++) begin
                node_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                for (int i = 0; i < N; i++) begin
                    node_q[N+i] <= {{L{mult_din[i*dwidth+dwidth-1]}},
                                    mult_din[i*dwidth +: dwidth]};
                end
            end
            for (int i = 1; i < N; i++) begin
                node_q[i] <= node_q[2*i] + node_q[2*i+1];
            end
            // Bubble tags travel with the data; only tagged roots accumulate.
            tag_q <= {tag_q[L-1:0], accept};

            if (start_ok) begin
                acc_q  <= '0;
                cnt_q  <= '0;
                len_q  <= vec_len;
                relu_q <= relu_en;
                bias_q <= bias;
            end else begin
                if (tag_q[L]) begin
                    acc_q <= acc_q
                           + {{(ACC_W-TW){node_q[1][TW-1]}}, node_q[1]};
                end
                if (accept) begin
                    cnt_q <= cnt_q + LEN_W'(1);
                end
            end

            // DRAIN countdown: L+1 covers the tree and the final add; an
            // empty vector only needs one settle cycle.
            if (start_ok) begin
                dcnt_q <= DCW'(1);
            end else if (last) begin
                dcnt_q <= DCW'(L + 1);
            end else if (state_q == S_DRAIN && dcnt_q != '0) begin
                dcnt_q <= dcnt_q - DCW'(1);
            end

            if (fire) begin
                dout_q <= res;
            end
        end
    end

endmodule

// File: tb/tb_fc_mult_accumulator.sv
// tb_fc_mult_accumulator: randomized scoreboard bench for fc_mult_accumulator
// with directed corner cases and an arithmetic reference model.
module tb_fc_mult_accumulator;

    localparam int DW = 16;
    localparam int PE = 8;
    localparam int NL = 2 * PE;
    localparam int LW = 10;
    localparam int LAT = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LW-1:0]     vec_len = '0;
    logic              relu_en = 1'b0;
    logic [DW-1:0]     bias = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NL*DW-1:0]  mult_din = '0;
    logic              busy;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DW-1:0]     dout;

    fc_mult_accumulator #(
        .dwidth(DW), .qwidth(11), .PE_Num(PE),
        .LEN_W(LW), .ACC_GUARD(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
        .relu_en(relu_en), .bias(bias), .in_valid(in_valid),
        .in_ready(in_ready), .mult_din(mult_din), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] d;
        int            rise;
    } exp_t;

    exp_t             sbq[$];
    logic [NL*DW-1:0] bq[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint a, input longint e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @cyc %0d",
                     nm, a, e, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s @cyc %0d", nm, cyc);
    endtask

    // Reference: signed dot product of the lanes plus bias, then clamp, then ReLU.
    function automatic logic [DW-1:0] model(input int len, input bit relu,
                                            input logic [DW-1:0] b);
        longint s;
        logic [NL*DW-1:0] v;
        s = longint'($signed(b));
        for (int k = 0; k < len; k++) begin
            v = bq[k];
            for (int i = 0; i < NL; i++) begin
                s += longint'($signed(v[i*DW +: DW]));
            end
        end
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return DW'(s);
    endfunction

    function automatic logic [NL*DW-1:0] rand_vec();
        logic [NL*DW-1:0] r;
        for (int i = 0; i < NL * DW / 32; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    function automatic logic [NL*DW-1:0] small_vec();
        logic [NL*DW-1:0] r;
        int v;
        for (int i = 0; i < NL; i++) begin
            v = int'($urandom_range(0, 511)) - 256;
            r[i*DW +: DW] = DW'(v);
        end
        return r;
    endfunction

    task automatic fill_const(input int len, input logic [DW-1:0] v);
        bq.delete();
        for (int k = 0; k < len; k++) begin
            bq.push_back({NL{v}});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: latency on the rising out_valid, value on every valid cycle.
    bit prev_v = 1'b0;
    always @(negedge clk) begin
        if (out_valid && !prev_v) begin
            if (sbq.size() == 0) begin
                fail("unexpected_out_valid");
            end else begin
                chk("latency", cyc, sbq[0].rise);
            end
        end
        if (out_valid && sbq.size() != 0) begin
            chk("dout", dout, sbq[0].d);
            if (out_ready) void'(sbq.pop_front());
        end
        prev_v = out_valid;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        if (busy) fail("idle_timeout");
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (sbq.size() != 0) begin
            fail("done_timeout");
            sbq.delete();
        end
        @(negedge clk);
        chk("idle_after_handshake", busy, 0);
        tick();
    endtask

    task automatic run_op(input int len, input bit relu,
                          input logic [DW-1:0] b, input int gap,
                          input bit extra);
        exp_t e;
        int acc_cyc;
        int g;
        int t;
        wait_idle();
        vec_len = LW'(len);
        relu_en = relu;
        bias    = b;
        start   = 1'b1;
        @(negedge clk);
        acc_cyc = cyc + 1;
        tick();
        start   = 1'b0;
        vec_len = LW'($urandom);
        relu_en = 1'($urandom);
        bias    = DW'($urandom);
        e.d = model(len, relu, b);
        if (len == 0) begin
            e.rise = acc_cyc + 2;
            sbq.push_back(e);
            in_valid = 1'b1;
            mult_din = rand_vec();
            repeat (3) begin
                @(negedge clk);
                chk("no_beats_ready", in_ready, 0);
                tick();
            end
            in_valid = 1'b0;
            return;
        end
        for (int k = 0; k < len; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            in_valid = 1'b0;
            mult_din = rand_vec();
            repeat (g) tick();
            in_valid = 1'b1;
            mult_din = bq[k];
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                fail("beat_timeout");
                in_valid = 1'b0;
                return;
            end
            acc_cyc = cyc + 1;
            tick();
        end
        e.rise = acc_cyc + LAT;
        sbq.push_back(e);
        in_valid = extra;
        mult_din = rand_vec();
        @(negedge clk);
        chk("ready_drop", in_ready, 0);
        tick();
        if (extra) repeat (2) tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int len;
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dout", dout, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // single beat, basic latency
        fill_const(1, 16'h0100);
        run_op(1, 1'b0, 16'h0000, 0, 1'b0);
        wait_done();

        // gapped beats, extra beats after the last must be ignored
        bq.delete();
        bq.push_back({NL{16'h0080}});
        bq.push_back({NL{16'h0040}});
        bq.push_back({NL{16'h0040}});
        run_op(3, 1'b0, 16'h0000, 2, 1'b1);
        wait_done();

        // negative saturation, then with ReLU
        fill_const(4, 16'hF800);
        run_op(4, 1'b0, 16'h0000, -1, 1'b0);
        wait_done();
        run_op(4, 1'b1, 16'h0000, -1, 1'b0);
        wait_done();

        // backpressure in OUT with a stray start pulse
        bq.delete();
        bq.push_back(small_vec());
        bq.push_back(small_vec());
        out_ready = 1'b0;
        run_op(2, 1'b0, DW'($urandom_range(0, 4095)), 0, 1'b0);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) fail("out_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            tick();
            start   = (i == 1);
            vec_len = '0;
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
        end
        tick();
        start = 1'b0;
        out_ready = 1'b1;
        wait_done();
        repeat (3) begin
            @(negedge clk);
            chk("stay_idle", busy, 0);
            tick();
        end

        // empty vector
        bq.delete();
        run_op(0, 1'b0, 16'h0400, 0, 1'b0);
        wait_done();

        // reset mid-operation, then a clean run
        wait_idle();
        fill_const(4, 16'h0700);
        vec_len = LW'(4);
        bias    = 16'h1234;
        start   = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        mult_din = bq[0];
        tick();
        mult_din = bq[1];
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_dout", dout, 0);
        repeat (10) tick();
        fill_const(1, 16'h0100);
        run_op(1, 1'b0, 16'h0000, 0, 1'b0);
        wait_done();

        // randomized operations
        repeat (30) begin
            len = int'($urandom_range(0, 6));
            bq.delete();
            for (int k = 0; k < len; k++) begin
                bq.push_back(($urandom_range(0, 1) == 1) ? rand_vec()
                                                          : small_vec());
            end
            run_op(len, 1'($urandom), DW'($urandom), -1, 1'($urandom));
            wait_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
